riscv_shared_dsp_arbiter: RTL and testbench

- Shares one pipelined dot-product/MAC unit between NB_CORES cores when the core-local multipliers are built with SHARED_DSP_MULT=1.
- Each cycle, selects at most one requesting core using round-robin arbitration and issues its operands to the shared unit.
- Tracks the owner of every in-flight operation and returns each result to that core exactly LATENCY cycles after issue.

---
 rtl/riscv_shared_dsp_arbiter.sv | 140 ++++++++++++++
 tb/tb_riscv_shared_dsp_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_shared_dsp_arbiter.sv
// Shares one pipelined dot-product/MAC unit among NB_CORES cores: round-robin picks one requester per cycle.
// Latency: grant and operand issue are combinational with req_i; each result returns LATENCY cycles after issue.
// Backpressure: the shared unit never stalls; a losing core holds req_i and its operands until granted.
module riscv_shared_dsp_arbiter #(
  parameter int NB_CORES = 4,
  parameter int LATENCY  = 2,
  parameter int ID_W     = $clog2(NB_CORES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NB_CORES-1:0]          req_i,
  output logic [NB_CORES-1:0]          gnt_o,
  input  logic [NB_CORES-1:0]          kill_i,
  input  logic [NB_CORES-1:0][2:0]     operator_i,
  input  logic [NB_CORES-1:0][1:0]     dot_signed_i,
  input  logic [NB_CORES-1:0][31:0]    op_a_i,
  input  logic [NB_CORES-1:0][31:0]    op_b_i,
  input  logic [NB_CORES-1:0][31:0]    op_c_i,
  input  logic [NB_CORES-1:0]          is_clpx_i,
  input  logic [NB_CORES-1:0]          clpx_img_i,
  input  logic [NB_CORES-1:0][1:0]     clpx_shift_i,
  output logic                         dsp_valid_o,
  output logic [2:0]                   dsp_operator_o,
  output logic [1:0]                   dsp_signed_o,
  output logic [31:0]                  dsp_op_a_o,
  output logic [31:0]                  dsp_op_b_o,
  output logic [31:0]                  dsp_op_c_o,
  output logic                         dsp_is_clpx_o,
  output logic                         dsp_clpx_img_o,
  output logic [1:0]                   dsp_clpx_shift_o,
  input  logic [31:0]                  dsp_result_i,
  output logic [NB_CORES-1:0]          r_valid_o,
  output logic [31:0]                  r_data_o,
  output logic                         busy_o
);

  // One extra bit so rr_ptr + offset never overflows before the wrap correction.
  localparam int SW = ID_W + 1;

  logic [ID_W-1:0]                rr_ptr;
  logic [ID_W-1:0]                win_id;
  logic                           win_found;
  logic [SW-1:0]                  rr_sum;
  logic [LATENCY-1:0]             tag_vld;
  logic [LATENCY-1:0][ID_W-1:0]   tag_id;

  // Round-robin search: first requester at or above rr_ptr, wrapping modulo NB_CORES.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    rr_sum    = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      rr_sum = {1'b0, rr_ptr} + SW'(i);
      if (rr_sum >= SW'(NB_CORES)) begin
        rr_sum = rr_sum - SW'(NB_CORES);
      end
      if (!win_found && req_i[rr_sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = rr_sum[ID_W-1:0];
      end
    end
  end

  // Grant is forced low while reset is held so nothing issues into a flushed pipeline.
  always_comb begin
    gnt_o = '0;
    if (rst_n && win_found) begin
      gnt_o[win_id] = 1'b1;
    end
  end

  assign dsp_valid_o = |gnt_o;

  // Operand mux; all-zero without a grant so the shared unit's inputs stay quiet.
  always_comb begin
    dsp_operator_o   = '0;
    dsp_signed_o     = '0;
    dsp_op_a_o       = '0;
    dsp_op_b_o       = '0;
    dsp_op_c_o       = '0;
    dsp_is_clpx_o    = 1'b0;
    dsp_clpx_img_o   = 1'b0;
    dsp_clpx_shift_o = '0;
    if (dsp_valid_o) begin
      dsp_operator_o   = operator_i[win_id];
      dsp_signed_o     = dot_signed_i[win_id];
      dsp_op_a_o       = op_a_i[win_id];
      dsp_op_b_o       = op_b_i[win_id];
      dsp_op_c_o       = op_c_i[win_id];
      dsp_is_clpx_o    = is_clpx_i[win_id];
      dsp_clpx_img_o   = clpx_img_i[win_id];
      dsp_clpx_shift_o = clpx_shift_i[win_id];
    end
  end

  // Pointer moves just past the winner, so the winner has lowest priority next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (dsp_valid_o) begin
      rr_ptr <= (win_id == ID_W'(NB_CORES - 1)) ? '0 : win_id + ID_W'(1);
    end
  end

  // Owner tags travel alongside the shared pipeline; a kill drops every tag of that core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= dsp_valid_o & ~kill_i[win_id];
      tag_id[0]  <= win_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1] & ~kill_i[tag_id[i-1]];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Final stage routes the unit's result to its owner; a same-cycle kill suppresses it.
  always_comb begin
    r_valid_o = '0;
    r_data_o  = '0;
    if (tag_vld[LATENCY-1] && !kill_i[tag_id[LATENCY-1]]) begin
      r_valid_o[tag_id[LATENCY-1]] = 1'b1;
      r_data_o                     = dsp_result_i;
    end
  end

  assign busy_o = |tag_vld;

  // Structural checks: single grant, and every delivered result had a grant LATENCY cycles ago.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_o));

  for (genvar j = 0; j < NB_CORES; j++) begin : g_rv_chk
    a_rv_origin: assert property (@(posedge clk) disable iff (!rst_n)
                                  r_valid_o[j] |-> $past(gnt_o[j], LATENCY));
  end

endmodule

// File: tb/tb_riscv_shared_dsp_arbiter.sv
// Bench for the shared DSP arbiter: directed scenarios then randomized traffic with kills and resets.
// Shared unit is modelled as a LATENCY-deep pipeline computing the dot product of the issued operands.
// A transaction-level model (issue list per cycle) predicts grants, deliveries, data and busy.
module tb_riscv_shared_dsp_arbiter;

  localparam int N = 4;
  localparam int L = 2;
  localparam logic [2:0] OP_DOT8  = 3'b100;
  localparam logic [2:0] OP_DOT16 = 3'b101;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req, kill, gnt;
  logic [N-1:0][2:0]  operator;
  logic [N-1:0][1:0]  dsig, shift;
  logic [N-1:0][31:0] a, b, c;
  logic [N-1:0]       clpx, img;
  logic               dsp_valid, dsp_is_clpx, dsp_clpx_img;
  logic [2:0]         dsp_operator;
  logic [1:0]         dsp_signed, dsp_clpx_shift;
  logic [31:0]        dsp_a, dsp_b, dsp_c, dsp_result, r_data;
  logic [N-1:0]       r_valid;
  logic               busy;

  logic [31:0] pipe [L];
  assign dsp_result = pipe[L-1];

  riscv_shared_dsp_arbiter #(.NB_CORES(N), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .kill_i(kill),
    .operator_i(operator), .dot_signed_i(dsig), .op_a_i(a), .op_b_i(b), .op_c_i(c),
    .is_clpx_i(clpx), .clpx_img_i(img), .clpx_shift_i(shift),
    .dsp_valid_o(dsp_valid), .dsp_operator_o(dsp_operator), .dsp_signed_o(dsp_signed),
    .dsp_op_a_o(dsp_a), .dsp_op_b_o(dsp_b), .dsp_op_c_o(dsp_c),
    .dsp_is_clpx_o(dsp_is_clpx), .dsp_clpx_img_o(dsp_clpx_img), .dsp_clpx_shift_o(dsp_clpx_shift),
    .dsp_result_i(dsp_result), .r_valid_o(r_valid), .r_data_o(r_data), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          core;
    int          t;
    logic [31:0] res;
    bit          alive;
  } op_t;

  op_t         ops[$];
  int          rr, cyc;
  int          n_total, n_bad;
  logic [N-1:0] last_g, obs_gnt, obs_rv;
  logic [31:0] obs_data;
  logic        obs_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference dot product: four byte lanes for DOT8, two halfword lanes for DOT16, plus accumulator.
  function automatic logic [31:0] dot(input logic [2:0] op, input logic [31:0] x, y, z);
    logic [31:0] s, xa, ya, m;
    int w, n;
    s = z;
    w = (op == OP_DOT16) ? 16 : 8;
    n = 32 / w;
    m = (op == OP_DOT16) ? 32'h0000FFFF : 32'h000000FF;
    for (int i = 0; i < n; i++) begin
      xa = (x >> (w * i)) & m;
      ya = (y >> (w * i)) & m;
      s  = s + xa * ya;
    end
    return s;
  endfunction

  task automatic new_ops(input int k);
    logic [31:0] r;
    r = $urandom;
    a[k] = $urandom;
    b[k] = $urandom;
    c[k] = $urandom;
    operator[k] = r[0] ? OP_DOT16 : OP_DOT8;
    dsig[k]  = r[2:1];
    clpx[k]  = r[3];
    img[k]   = r[4];
    shift[k] = r[6:5];
  endtask

  // One clock: called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    logic [N-1:0] eg, erv;
    logic [31:0]  edata, cap;
    bit           ebusy;
    int           w;
    op_t          o;
    @(negedge clk);
    eg = '0; erv = '0; edata = '0; ebusy = 0; w = -1;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        int k = (rr + i) % N;
        if (w < 0 && req[k]) w = k;
      end
      if (w >= 0) eg[w] = 1'b1;
      foreach (ops[i]) begin
        if (ops[i].alive && ops[i].t >= cyc - L && ops[i].t <= cyc - 1) ebusy = 1;
        if (ops[i].alive && ops[i].t == cyc - L && !kill[ops[i].core]) begin
          erv[ops[i].core] = 1'b1;
          edata = ops[i].res;
        end
      end
    end
    check("gnt", 32'(gnt), 32'(eg));
    check("dsp_valid", 32'(dsp_valid), 32'(w >= 0));
    if (w >= 0) begin
      check("dsp_a", dsp_a, a[w]);
      check("dsp_b", dsp_b, b[w]);
      check("dsp_c", dsp_c, c[w]);
      check("dsp_ctl", 32'({dsp_operator, dsp_signed, dsp_is_clpx, dsp_clpx_img, dsp_clpx_shift}),
            32'({operator[w], dsig[w], clpx[w], img[w], shift[w]}));
    end else begin
      check("dsp_idle", 32'({dsp_operator, dsp_signed, dsp_is_clpx, dsp_clpx_img, dsp_clpx_shift})
            | dsp_a | dsp_b | dsp_c, 32'h0);
    end
    check("busy", 32'(busy), 32'(ebusy));
    check("r_valid", 32'(r_valid), 32'(erv));
    if (erv != '0) check("r_data", r_data, edata);
    else if (!ebusy) check("r_data_idle", r_data, 32'h0);
    obs_gnt = gnt; obs_rv = r_valid; obs_data = r_data; obs_busy = busy;
    cap = dsp_valid ? dot(dsp_operator, dsp_a, dsp_b, dsp_c) : $urandom;
    if (!rst_n) begin
      ops.delete();
      rr = 0;
    end else begin
      foreach (ops[i]) if (kill[ops[i].core]) ops[i].alive = 0;
      if (w >= 0) begin
        o.core = w; o.t = cyc; o.res = dot(operator[w], a[w], b[w], c[w]); o.alive = !kill[w];
        ops.push_back(o);
        rr = (w + 1) % N;
      end
      while (ops.size() > 0 && ops[0].t <= cyc - L) void'(ops.pop_front());
    end
    last_g = eg;
    cyc++;
    @(posedge clk);
    #1;
    for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = cap;
    if (w >= 0) new_ops(w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '1; kill = '0;
    cycle();
    rst_n = 1'b1; req = '0;
  endtask

  initial begin
    n_total = 0; n_bad = 0; rr = 0; cyc = 0; last_g = '0;
    rst_n = 1'b0; req = '0; kill = '0;
    for (int i = 0; i < L; i++) pipe[i] = '0;
    for (int k = 0; k < N; k++) new_ops(k);
    @(posedge clk); #1;

    // Single core, known dot product
    do_reset();
    req = 4'b0001; a[0] = 32'h01020304; b[0] = 32'h01010101; c[0] = 32'h0; operator[0] = OP_DOT8;
    cycle();
    check("t1_gnt", 32'(obs_gnt), 32'h1);
    req = '0;
    cycle();
    check("t1_busy1", 32'(obs_busy), 32'h1);
    cycle();
    check("t1_rv", 32'(obs_rv), 32'h1);
    check("t1_data", obs_data, 32'h0000000A);
    check("t1_busy2", 32'(obs_busy), 32'h1);
    cycle();
    check("t1_busy_end", 32'(obs_busy), 32'h0);

    // All cores requesting: strict rotation from core 0
    do_reset();
    req = '1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_order", 32'(obs_gnt), 32'(1) << (i % N));
    end
    req = '0;
    repeat (3) cycle();

    // Pointer rotation from rr_ptr=2
    do_reset();
    req = 4'b0010;
    cycle();
    req = 4'b1011;
    cycle();
    check("rot_a", 32'(obs_gnt), 32'h8);
    cycle();
    check("rot_b", 32'(obs_gnt), 32'h1);
    req = '0;
    repeat (3) cycle();

    // Kill of core 1's in-flight op while core 2 issues
    do_reset();
    req = 4'b0010;
    cycle();
    req = 4'b0100; kill = 4'b0010;
    cycle();
    req = '0; kill = '0;
    cycle();
    check("kill_t2", 32'(obs_rv), 32'h0);
    cycle();
    check("kill_t3", 32'(obs_rv), 32'h4);

    // Reset mid-flight
    do_reset();
    req = 4'b0001;
    cycle();
    req = 4'b0010;
    cycle();
    rst_n = 1'b0; req = '1;
    cycle();
    check("rst_rv", 32'(obs_rv), 32'h0);
    check("rst_busy", 32'(obs_busy), 32'h0);
    rst_n = 1'b1; req = '1;
    cycle();
    check("rst_first", 32'(obs_gnt), 32'h1);
    req = '0;
    repeat (3) cycle();

    // Back-to-back single core
    do_reset();
    req = 4'b0001;
    repeat (3) begin
      cycle();
      check("b2b_gnt", 32'(obs_gnt), 32'h1);
    end
    req = '0;
    repeat (3) cycle();

    // Randomized traffic with kills and occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] pend;
      pend = req & ~last_g;
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          req[k] = ($urandom % 8) != 0;
        end else begin
          new_ops(k);
          req[k] = ($urandom % 2) != 0;
        end
        kill[k] = ($urandom % 12) == 0;
      end
      rst_n = ($urandom % 250) != 0;
      cycle();
    end
    rst_n = 1'b1; req = '0; kill = '0;
    repeat (L + 1) cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
